multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent switch channels, 1..32.
REQ-002 Parameter CNT_W, default 16: stability counter width.
REQ-003 Parameter DELAY_CNT, default 3: consecutive differing samples required to accept a change; 2 <= DELAY_CNT < 2**CNT_W.
REQ-004 Port clk, input, 1: clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port sw, input, NUM_CH: raw switch levels, one bit per channel.
REQ-007 Port out, output, NUM_CH: registered debounced levels.
REQ-008 Port rise, output, NUM_CH: registered one-cycle pulse when out[i] goes 0->1.
REQ-009 Port fall, output, NUM_CH: registered one-cycle pulse when out[i] goes 1->0.

Function
REQ-010 Each channel SHALL run an independent FSM, states STABLE and CHECK, with a CNT_W-bit counter cnt; channels share no state.
REQ-011 The sample s[i] SHALL be sw[i] directly, or the synchronizer output when DEBOUNCE_SYNC_EN is defined.
REQ-012 STABLE: s == out -> stay, cnt = 0; s != out -> go to CHECK, cnt = 1.
REQ-013 CHECK: s == out -> go to STABLE, cnt = 0, out unchanged, no pulse (glitch rejected).
REQ-014 CHECK: s != out and cnt == DELAY_CNT-1 -> out <= s, go to STABLE, cnt = 0, raise rise or fall for exactly that one cycle.
REQ-015 CHECK: s != out and cnt < DELAY_CNT-1 -> cnt <= cnt + 1, stay.
REQ-016 Latency: out[i] SHALL update on the DELAY_CNT-th consecutive rising edge at which s[i] != out[i]; any intervening sample equal to out restarts the count.
REQ-017 rise[i] and fall[i] SHALL never both be 1, and SHALL be 0 on every cycle in which out[i] does not change.
REQ-018 Simultaneous changes on several channels SHALL yield pulses in the same cycle on each of them.
REQ-019 cnt SHALL never exceed DELAY_CNT-1; no wrap-around is reachable.

Reset
REQ-020 While rst_n is low: out = 0, rise = 0, fall = 0, every FSM in STABLE, cnt = 0, synchronizer flops = 0.
REQ-021 Reset asserted mid-CHECK SHALL discard the partial count; after release, a change needs DELAY_CNT fresh samples.
REQ-022 Immediately after release, a channel with sw = 1 SHALL be treated as a 0->1 change and produce a rise pulse.

Configuration
REQ-023 Macro DEBOUNCE_SYNC_EN defined: each sw bit passes through a two-flop synchronizer before sampling, adding 2 cycles of latency.
REQ-024 Macro DEBOUNCE_SYNC_EN undefined: sw is sampled directly; inputs are required to be synchronous to clk.

Structure
REQ-025 Package debounce_pkg SHALL hold the FSM state enum (STABLE, CHECK) and the default constants for DELAY_CNT and CNT_W.
REQ-026 Sub-module debounce_ch SHALL implement one channel (sync option, FSM, counter, pulses); multi_debounce instantiates NUM_CH copies through a generate loop.

Verification
Setup for REQ-027 to REQ-031: NUM_CH=4, DELAY_CNT=3, no DEBOUNCE_SYNC_EN.
REQ-027 Reset: hold rst_n low with sw=4'hF -> out=0, rise=fall=0. Release -> out=4'hF on the 3rd edge; rise=4'hF for that one cycle only.
REQ-028 Glitch: sw[0] high for 2 cycles, then low -> out[0] stays 0; rise[0] and fall[0] stay 0 throughout.
REQ-029 Bounce: sw[1] samples 1,0,1,0, then held at 1 -> out[1] rises on the 3rd edge after the final 0->1; exactly one rise[1] pulse.
REQ-030 Simultaneous: out=4'b1000, then sw=4'b0100 -> on the same edge out=4'b0100, rise=4'b0100, fall=4'b1000.
REQ-031 Reset mid-CHECK: sw[2] differs for 2 edges, pulse rst_n low, sw[2] held -> out[2] changes only on the 3rd edge after release.
REQ-032 DEBOUNCE_SYNC_EN defined: a clean sw[3] 0->1 step -> out[3] and rise[3] assert on the 5th edge after the step.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the multi-channel switch debouncer.
package debounce_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } db_state_e;

  // Default stability counter width.
  localparam int DEFAULT_CNT_W     = 16;

  // Default number of consecutive differing samples needed to accept a change.
  localparam int DEFAULT_DELAY_CNT = 3;

endpackage : debounce_pkg

// File: rtl/debounce_ch.sv
// Single debounce channel: optional two-flop input synchronizer, STABLE/CHECK
// FSM with a stability counter, registered debounced level and edge pulses.
// Optional feature macro: DEBOUNCE_SYNC_EN (adds a 2-flop synchronizer on sw_i).
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int DELAY_CNT = DEFAULT_DELAY_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  // Count value at which a pending change is accepted, and the CHECK entry value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             accept;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer bringing the asynchronous switch level into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sw_i};
    end
  end

  assign s = sync_q[1];
`else
  assign s = sw_i;
`endif

  // State register: FSM state, counter and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop here is small control state, so all of it is reset; the
    // partial count must be discarded on reset so a change needs fresh samples.
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: track how many consecutive samples differ from out.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (s != out_q) begin
          state_d = CHECK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      CHECK: begin
        if (s == out_q) begin
          // Glitch rejected: the sample returned to the accepted level.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Output logic: next debounced level and one-cycle edge pulses on accept.
  always_comb begin
    out_d  = accept ? s : out_q;
    rise_d = accept &  s;
    fall_d = accept & ~s;
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : debounce_ch

// File: rtl/multi_debounce.sv
// NUM_CH independent switch debouncers with registered level and edge pulses.
// Optional feature macro: DEBOUNCE_SYNC_EN (per-bit 2-flop input synchronizer,
// handled inside debounce_ch).
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int DELAY_CNT = DEFAULT_DELAY_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sw,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  // One fully independent channel per switch bit; channels share no state.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W     (CNT_W),
      .DELAY_CNT (DELAY_CNT)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_i   (sw[i]),
      .out_o  (out[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

endmodule : multi_debounce

// File: tb/tb_multi_debounce.sv
// Directed self-checking bench for multi_debounce (NUM_CH=4, DELAY_CNT=3,
// default build without the input synchronizer).
module tb_multi_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] out;
  logic [3:0] rise;
  logic [3:0] fall;

  int vectors     = 0;
  int miscompares = 0;

  multi_debounce #(
    .NUM_CH    (4),
    .CNT_W     (16),
    .DELAY_CNT (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .out   (out),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_out,
                           input logic [3:0] e_rise, input logic [3:0] e_fall);
    check({tag, ".out"},  out,  e_out);
    check({tag, ".rise"}, rise, e_rise);
    check({tag, ".fall"}, fall, e_fall);
  endtask

  // Advance one rising edge, then compare away from the edge.
  task automatic step(input string tag, input logic [3:0] e_out,
                      input logic [3:0] e_rise, input logic [3:0] e_fall);
    @(posedge clk);
    #1;
    check_all(tag, e_out, e_rise, e_fall);
  endtask

  initial begin
    // Reset held with all switches high.
    rst_n = 1'b0;
    sw    = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 4'h0, 4'h0, 4'h0);

    // Release: high switches count as a 0->1 change, accepted on the 3rd edge.
    rst_n = 1'b1;
    step("rel_e1", 4'h0, 4'h0, 4'h0);
    step("rel_e2", 4'h0, 4'h0, 4'h0);
    step("rel_e3", 4'hF, 4'hF, 4'h0);
    step("rel_e4", 4'hF, 4'h0, 4'h0);

    // All switches released together.
    sw = 4'h0;
    step("low_e1", 4'hF, 4'h0, 4'h0);
    step("low_e2", 4'hF, 4'h0, 4'h0);
    step("low_e3", 4'h0, 4'h0, 4'hF);
    step("low_e4", 4'h0, 4'h0, 4'h0);

    // Glitch: sw[0] high for only 2 samples is rejected.
    sw = 4'b0001;
    step("glitch_h1", 4'h0, 4'h0, 4'h0);
    step("glitch_h2", 4'h0, 4'h0, 4'h0);
    sw = 4'b0000;
    step("glitch_l1", 4'h0, 4'h0, 4'h0);
    step("glitch_l2", 4'h0, 4'h0, 4'h0);
    step("glitch_l3", 4'h0, 4'h0, 4'h0);

    // Bounce on sw[1]: 1,0,1,0 then held 1 -> accepted on 3rd held edge.
    sw = 4'b0010;
    step("bounce_1", 4'h0, 4'h0, 4'h0);
    sw = 4'b0000;
    step("bounce_2", 4'h0, 4'h0, 4'h0);
    sw = 4'b0010;
    step("bounce_3", 4'h0, 4'h0, 4'h0);
    sw = 4'b0000;
    step("bounce_4", 4'h0, 4'h0, 4'h0);
    sw = 4'b0010;
    step("bounce_h1", 4'h0,    4'h0,    4'h0);
    step("bounce_h2", 4'h0,    4'h0,    4'h0);
    step("bounce_h3", 4'b0010, 4'b0010, 4'h0);
    step("bounce_h4", 4'b0010, 4'h0,    4'h0);
    step("bounce_h5", 4'b0010, 4'h0,    4'h0);

    // Move to out=1000 (rise on ch3 and fall on ch1 together).
    sw = 4'b1000;
    step("to8_e1", 4'b0010, 4'h0,    4'h0);
    step("to8_e2", 4'b0010, 4'h0,    4'h0);
    step("to8_e3", 4'b1000, 4'b1000, 4'b0010);
    step("to8_e4", 4'b1000, 4'h0,    4'h0);

    // Simultaneous: 1000 -> 0100 on the same edge.
    sw = 4'b0100;
    step("sim_e1", 4'b1000, 4'h0,    4'h0);
    step("sim_e2", 4'b1000, 4'h0,    4'h0);
    step("sim_e3", 4'b0100, 4'b0100, 4'b1000);
    step("sim_e4", 4'b0100, 4'h0,    4'h0);

    // Return to all-low before the reset-mid-CHECK case.
    sw = 4'b0000;
    step("clr_e1", 4'b0100, 4'h0, 4'h0);
    step("clr_e2", 4'b0100, 4'h0, 4'h0);
    step("clr_e3", 4'b0000, 4'h0, 4'b0100);

    // Reset mid-CHECK: 2 differing samples, then reset discards the count.
    sw = 4'b0100;
    step("mid_e1", 4'h0, 4'h0, 4'h0);
    step("mid_e2", 4'h0, 4'h0, 4'h0);
    #1 rst_n = 1'b0;
    #1 check_all("mid_rst", 4'h0, 4'h0, 4'h0);
    #1 rst_n = 1'b1;
    step("post_e1", 4'h0,    4'h0,    4'h0);
    step("post_e2", 4'h0,    4'h0,    4'h0);
    step("post_e3", 4'b0100, 4'b0100, 4'h0);
    step("post_e4", 4'b0100, 4'h0,    4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_multi_debounce
